hilo_md_sequencer: RTL and testbench
====================================

// Module: hilo_md_sequencer
// PURPOSE
//  Sequences the multi-cycle MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU operations decoded in ID and owns the HI/LO register pair.
//  Sits beside the EX stage.
//  Holds the pipeline via stall_o while an operation runs, and commits the result to HI/LO.
//  Also performs single-cycle MTHI/MTLO writes.
//  Aborts cleanly on pipeline flush (exception/eret).
// PARAMETERS
//  MUL_CYCLES   2       multiply occupancy in MUL state, cycles (legal 1..8)
//  HILO_RST     32'h0   reset value of HI and LO
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  op_valid_i   in   1   EX holds a HI/LO-class instruction this cycle
//  op_i         in   4   0 MULT,1 MULTU,2 DIV,3 DIVU,4 MADD,5 MADDU,6 MSUB,7 MSUBU,8 MTHI,9 MTLO; 10-15 ignored
//  rs_val_i     in   32  rs operand (dividend / multiplicand / MTxx source)
//  rt_val_i     in   32  rt operand (divisor / multiplier)
//  flush_i      in   1   pipeline flush; aborts current op
//  stall_o      out  1   hold IF..EX this cycle
//  busy_o       out  1   state != IDLE
//  done_o       out  1   one-cycle pulse in the WB cycle
//  hi_o         out  32  HI register
//  lo_o         out  32  LO register
// BEHAVIOUR
//  Reset: state=IDLE; HI=LO=HILO_RST; stall_o=busy_o=done_o=0; counter=0.
//  States and transitions:
//   - IDLE: on op_valid_i & !flush_i & op in 0-7: latch operands and op, and assert stall_o (combinational).
//     Ops 0,1,4-7 go to MUL with cnt=MUL_CYCLES-1. Ops 2,3 go to DIV with cnt=31.
//   - MUL: stall_o=1. Go to WB when cnt==0, else cnt--.
//     The 64-bit product is computed from latched operands (signed for 0,4,6; unsigned for 1,5,7).
//   - DIV: stall_o=1. One restoring step per cycle on |operands|. Go to WB when cnt==0, else cnt--.
//   - WB: stall_o=0, done_o=1. HI/LO are written at the end of this cycle. Next state is IDLE.
//  Latency: stall_o is high for 1+MUL_CYCLES cycles (mul) and 33 cycles (div). HI/LO are visible the cycle after WB.
//  Commit rules:
//   - MULT/MULTU: {HI,LO} = product.
//   - MADD/MADDU: {HI,LO} = {HI,LO} + product, 64-bit wrap.
//   - MSUB/MSUBU: {HI,LO} = {HI,LO} - product, 64-bit wrap. The accumulate uses HI/LO as they stand at WB.
//   - DIV: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
//     0x80000000 / -1 gives LO=0x80000000, HI=0, no trap.
//   - Divide by zero (DIV or DIVU): LO=32'hFFFFFFFF, HI=rs. Still takes the full 33 cycles.
//  MTHI/MTLO: in IDLE, write HI or LO at the clock edge with no stall, no done_o, and no state change.
//   When busy, an MTxx (or any new op) with op_valid_i keeps stall_o=1 and is not accepted.
//   EX holds it; it is accepted in the first IDLE cycle after WB.
//  Back-to-back: an op presented during WB is not accepted. The next op is accepted in the following IDLE cycle.
//  Flush:
//   - flush_i in MUL, DIV or WB: next state IDLE, HI/LO not written, done_o=0 in that cycle.
//     stall_o=0 in the flush cycle (flush overrides stall).
//   - flush_i with op_valid_i in IDLE: op not accepted, MTxx not written.
//  op_valid_i=0 or op 10-15 in IDLE: no effect.
//  rst asserted mid-operation: immediate return to reset values; partial result discarded.
// TESTING
//  1. MULT rs=-2, rt=3, MUL_CYCLES=2 -> stall_o high 3 cycles; HI=FFFFFFFF, LO=FFFFFFFA.
//  2. DIV rs=7, rt=-2 -> stall_o high 33 cycles, done_o at cycle 33; LO=FFFFFFFD, HI=00000001.
//     DIVU rs=7, rt=2 -> LO=3, HI=1.
//  3. MADD with HI=0, LO=FFFFFFFF, rs=1, rt=1 -> HI=1, LO=0.
//     MSUBU afterwards with rs=2, rt=1 -> HI=0, LO=FFFFFFFE.
//  4. DIV rt=0, rs=0x1234 -> LO=FFFFFFFF, HI=00001234.
//     DIV rs=80000000, rt=FFFFFFFF -> LO=80000000, HI=0.
//  5. DIV started, flush_i at cycle 10 -> IDLE next cycle, stall_o=0, HI/LO unchanged, done_o never pulses.
//     rst pulse mid-MUL -> HI=LO=HILO_RST.
//  6. MTHI 0xAA in IDLE -> HI=AA next cycle, no stall.
//     MTLO held during a DIV -> stalled until after WB, then LO written; DIV result in HI preserved.

Source files
------------

// File: rtl/hilo_md_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_md_sequencer
//  Purpose  : Sequences multi-cycle MULT/MULTU/DIV/DIVU/MADD(U)/MSUB(U) ops
//             issued from EX and owns the HI/LO register pair. Holds the
//             pipeline with stall_o while an op runs, commits in a WB cycle,
//             performs single-cycle MTHI/MTLO, and aborts on flush_i.
//  Ports    : clk, rst (async, active-high)
//             op_valid_i, op_i[3:0], rs_val_i[31:0], rt_val_i[31:0], flush_i
//             stall_o, busy_o, done_o, hi_o[31:0], lo_o[31:0]
//  Revision : 1.0 - initial release
// ============================================================================
module hilo_md_sequencer #(
    parameter int          MUL_CYCLES = 2,
    parameter logic [31:0] HILO_RST   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] rt_val_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_CNT_INIT = 5'd31;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] rs_q;
    logic [31:0] rt_q;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dmag;
    logic        q_neg;
    logic        r_neg;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // Issue decode (only meaningful in IDLE)
    logic        in_div;
    logic        in_signed;
    logic        accept;
    logic        mt_write;
    logic [31:0] rs_abs;
    logic [31:0] rt_abs;

    assign in_div    = (op_i[3:1] == 3'b001);
    // DIV/MULT/MADD/MSUB (even codes) are the signed variants
    assign in_signed = ~op_i[0];
    assign accept    = (state == IDLE) && op_valid_i && !flush_i && !op_i[3];
    assign mt_write  = (state == IDLE) && op_valid_i && !flush_i && (op_i[3:1] == 3'b100);
    assign rs_abs    = (in_signed && rs_val_i[31]) ? (32'd0 - rs_val_i) : rs_val_i;
    assign rt_abs    = (in_signed && rt_val_i[31]) ? (32'd0 - rt_val_i) : rt_val_i;

    // Datapath: product, one restoring-divide step, final commit values
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] q_fin;
    logic [31:0] r_fin;
    logic [63:0] acc;
    logic [63:0] res;

    always_comb begin
        ext_a   = op_q[0] ? {32'd0, rs_q} : {{32{rs_q[31]}}, rs_q};
        ext_b   = op_q[0] ? {32'd0, rt_q} : {{32{rt_q[31]}}, rt_q};
        // Low 64 bits of the sign/zero-extended product are exact either way
        product = ext_a * ext_b;
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, dmag};
        q_fin   = q_neg ? (32'd0 - quo) : quo;
        r_fin   = r_neg ? (32'd0 - rem) : rem;
        acc     = {hi_q, lo_q};
        res     = acc;
        case (op_q)
            3'd0, 3'd1: res = product;
            3'd4, 3'd5: res = acc + product;
            3'd6, 3'd7: res = acc - product;
            default: begin
                if (rt_q == 32'd0) begin
                    res = {rs_q, 32'hFFFF_FFFF};
                end else begin
                    res = {r_fin, q_fin};
                end
            end
        endcase
    end

    // Next state and handshake outputs; flush always wins over stall
    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        done_o    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall_o   = 1'b1;
                    state_nxt = in_div ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                if (flush_i) begin
                    state_nxt = IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (cnt == 5'd0) begin
                        state_nxt = WB;
                    end
                end
            end
            WB: begin
                state_nxt = IDLE;
                done_o    = !flush_i;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_o = (state != IDLE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
            op_q  <= 3'd0;
            rs_q  <= 32'd0;
            rt_q  <= 32'd0;
            quo   <= 32'd0;
            rem   <= 32'd0;
            dmag  <= 32'd0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            hi_q  <= HILO_RST;
            lo_q  <= HILO_RST;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= op_i[2:0];
                rs_q  <= rs_val_i;
                rt_q  <= rt_val_i;
                cnt   <= in_div ? DIV_CNT_INIT : MUL_CNT_INIT;
                quo   <= rs_abs;
                rem   <= 32'd0;
                dmag  <= rt_abs;
                q_neg <= in_div && in_signed && (rs_val_i[31] ^ rt_val_i[31]);
                r_neg <= in_div && in_signed && rs_val_i[31];
            end
            if (((state == MUL) || (state == DIV)) && !flush_i && (cnt != 5'd0)) begin
                cnt <= cnt - 5'd1;
            end
            // Restoring step on magnitudes: keep the trial difference if it
            // did not borrow, shifting the new quotient bit in from the right
            if ((state == DIV) && !flush_i) begin
                if (!diff[32]) begin
                    rem <= diff[31:0];
                    quo <= {quo[30:0], 1'b1};
                end else begin
                    rem <= shifted[31:0];
                    quo <= {quo[30:0], 1'b0};
                end
            end
            if (mt_write) begin
                if (op_i[0]) begin
                    lo_q <= rs_val_i;
                end else begin
                    hi_q <= rs_val_i;
                end
            end
            if ((state == WB) && !flush_i) begin
                hi_q <= res[63:32];
                lo_q <= res[31:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_md_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hilo_md_sequencer
//  Purpose  : Self-checking bench for hilo_md_sequencer. A cycle-level
//             reference model computes results with plain integer arithmetic
//             and is compared every cycle; directed literals pin the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_md_sequencer;

    localparam int          MUL_CYCLES = 2;
    localparam logic [31:0] HILO_RST   = 32'h0;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        flush;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int total = 0;
    int bad   = 0;
    int stall_cnt;
    int done_cnt;

    hilo_md_sequencer #(
        .MUL_CYCLES (MUL_CYCLES),
        .HILO_RST   (HILO_RST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid_i (op_valid),
        .op_i       (op),
        .rs_val_i   (rs),
        .rt_val_i   (rt),
        .flush_i    (flush),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_hi, m_lo, m_rs, m_rt;
    logic [3:0]  m_op;
    int          m_left = 0;   // running cycles still to go before WB
    bit          m_wb   = 0;

    task automatic commit();
        longint      sa, sb, ua, ub;
        logic [63:0] p, acc;
        int          a, b;
        sa  = longint'(int'(m_rs));
        sb  = longint'(int'(m_rt));
        ua  = longint'({32'd0, m_rs});
        ub  = longint'({32'd0, m_rt});
        acc = {m_hi, m_lo};
        p   = (m_op[0] == 1'b0) ? 64'(sa * sb) : 64'(ua * ub);
        case (m_op)
            4'd0, 4'd1: {m_hi, m_lo} = p;
            4'd4, 4'd5: {m_hi, m_lo} = acc + p;
            4'd6, 4'd7: {m_hi, m_lo} = acc - p;
            default: begin
                if (m_rt == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = m_rs;
                end else if (m_op == 4'd2) begin
                    if (m_rs == 32'h8000_0000 && m_rt == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000;
                        m_hi = 32'd0;
                    end else begin
                        a    = int'(m_rs);
                        b    = int'(m_rt);
                        m_lo = 32'(a / b);
                        m_hi = 32'(a % b);
                    end
                end else begin
                    m_lo = m_rs / m_rt;
                    m_hi = m_rs % m_rt;
                end
            end
        endcase
    endtask

    always @(negedge clk) begin
        logic e_stall, e_busy, e_done;
        e_stall = 1'b0;
        e_busy  = 1'b0;
        e_done  = 1'b0;
        if (!rst) begin
            if (m_wb) begin
                e_busy = 1'b1;
                e_done = !flush;
            end else if (m_left > 0) begin
                e_busy  = 1'b1;
                e_stall = !flush;
            end else begin
                e_stall = op_valid && !flush && !op[3];
            end
        end
        chk("stall", {63'd0, stall_o}, {63'd0, e_stall});
        chk("busy",  {63'd0, busy_o},  {63'd0, e_busy});
        chk("done",  {63'd0, done_o},  {63'd0, e_done});
        chk("hi",    {32'd0, hi_o},    {32'd0, (rst ? HILO_RST : m_hi)});
        chk("lo",    {32'd0, lo_o},    {32'd0, (rst ? HILO_RST : m_lo)});
        if (rst) begin
            m_hi   = HILO_RST;
            m_lo   = HILO_RST;
            m_left = 0;
            m_wb   = 0;
        end else if (m_wb) begin
            m_wb = 0;
            if (!flush) commit();
        end else if (m_left > 0) begin
            if (flush) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) m_wb = 1;
            end
        end else if (op_valid && !flush) begin
            if (op <= 4'd7) begin
                m_op   = op;
                m_rs   = rs;
                m_rt   = rt;
                m_left = (op == 4'd2 || op == 4'd3) ? 32 : MUL_CYCLES;
            end else if (op == 4'd8) begin
                m_hi = rs;
            end else if (op == 4'd9) begin
                m_lo = rs;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; holds the vector for n cycles, ends at posedge+1
    task automatic drive(input logic v, input logic f, input logic [3:0] o,
                         input logic [31:0] a, input logic [31:0] b, input int n);
        op_valid  = v;
        flush     = f;
        op        = o;
        rs        = a;
        rt        = b;
        stall_cnt = 0;
        done_cnt  = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (stall_o) stall_cnt++;
            if (done_o)  done_cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, n);
    endtask

    initial begin
        rst      = 1'b1;
        op_valid = 1'b0;
        flush    = 1'b0;
        op       = 4'd0;
        rs       = 32'd0;
        rt       = 32'd0;
        @(posedge clk);
        #1;
        chk("rst_hi", {32'd0, hi_o}, {32'd0, HILO_RST});
        chk("rst_lo", {32'd0, lo_o}, {32'd0, HILO_RST});
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // MULT -2 * 3
        drive(1'b1, 1'b0, 4'd0, 32'hFFFF_FFFE, 32'd3, 2 + MUL_CYCLES);
        chk("mult_stall", 64'(stall_cnt), 64'd3);
        chk("mult_done",  64'(done_cnt),  64'd1);
        chk("mult_res", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
        idle(1);

        // DIV 7 / -2, DIVU 7 / 2
        drive(1'b1, 1'b0, 4'd2, 32'd7, 32'hFFFF_FFFE, 34);
        chk("div_stall", 64'(stall_cnt), 64'd33);
        chk("div_done",  64'(done_cnt),  64'd1);
        chk("div_res", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFD);
        drive(1'b1, 1'b0, 4'd3, 32'd7, 32'd2, 34);
        chk("divu_res", {hi_o, lo_o}, 64'h0000_0001_0000_0003);
        idle(1);

        // MADD then MSUBU accumulate
        drive(1'b1, 1'b0, 4'd8, 32'd0, 32'd0, 1);
        drive(1'b1, 1'b0, 4'd9, 32'hFFFF_FFFF, 32'd0, 1);
        drive(1'b1, 1'b0, 4'd4, 32'd1, 32'd1, 2 + MUL_CYCLES);
        chk("madd_res", {hi_o, lo_o}, 64'h0000_0001_0000_0000);
        drive(1'b1, 1'b0, 4'd7, 32'd2, 32'd1, 2 + MUL_CYCLES);
        chk("msubu_res", {hi_o, lo_o}, 64'h0000_0000_FFFF_FFFE);
        idle(1);

        // Divide by zero and the signed overflow corner
        drive(1'b1, 1'b0, 4'd2, 32'h0000_1234, 32'd0, 34);
        chk("div0_stall", 64'(stall_cnt), 64'd33);
        chk("div0_res", {hi_o, lo_o}, 64'h0000_1234_FFFF_FFFF);
        drive(1'b1, 1'b0, 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34);
        chk("divovf_res", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
        idle(1);

        // Flush in cycle 10 of a DIV
        drive(1'b1, 1'b0, 4'd2, 32'd100, 32'd7, 9);
        drive(1'b1, 1'b1, 4'd2, 32'd100, 32'd7, 1);
        chk("flush_stall", 64'(stall_cnt), 64'd0);
        idle(40);
        chk("flush_done", 64'(done_cnt), 64'd0);
        chk("flush_res", {hi_o, lo_o}, 64'h0000_0000_8000_0000);

        // Flush with an MTHI in IDLE: not written
        drive(1'b1, 1'b1, 4'd8, 32'h55, 32'd0, 1);
        chk("flush_mthi", {32'd0, hi_o}, 64'd0);

        // Ignored opcode in IDLE
        drive(1'b1, 1'b0, 4'd12, 32'h77, 32'h77, 3);
        chk("op12_stall", 64'(stall_cnt), 64'd0);

        // Reset pulse mid-MUL
        drive(1'b1, 1'b0, 4'd8, 32'hBEEF, 32'd0, 1);
        drive(1'b1, 1'b0, 4'd0, 32'd3, 32'd3, 2);
        op_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstmid_res", {hi_o, lo_o}, {HILO_RST, HILO_RST});
        chk("rstmid_busy", {63'd0, busy_o}, 64'd0);
        idle(2);

        // MTHI in IDLE, then MTLO held behind a DIV
        drive(1'b1, 1'b0, 4'd8, 32'hAA, 32'd0, 1);
        chk("mthi_stall", 64'(stall_cnt), 64'd0);
        chk("mthi_hi", {32'd0, hi_o}, 64'hAA);
        drive(1'b1, 1'b0, 4'd2, 32'd9, 32'd4, 1);
        drive(1'b1, 1'b0, 4'd9, 32'h5555, 32'd0, 34);
        chk("mtlo_stall", 64'(stall_cnt), 64'd32);
        chk("mtlo_res", {hi_o, lo_o}, 64'h0000_0001_0000_5555);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
